// File: rtl/race_pkg.sv
// Shared definitions for the racing game flow controller: FSM state
// encodings and the widths/limits of score, level and velocity.
package race_pkg;

    localparam int VEL_W   = 4;
    localparam int LEVEL_W = 4;
    localparam int SCORE_W = 14;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_CRASH     = 3'd3,
        ST_GAMEOVER  = 3'd4
    } race_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: registers the active-low VGA vsync level twice and
// emits a one-cycle tick when the sampled value goes from 1 to 0, so there
// is exactly one tick per frame.
module frame_tick_gen (
    input  logic iVGA_CLK,
    input  logic reset_game,
    input  logic iVsync,
    output logic oTick
);

    logic vsync_cur;
    logic vsync_prev;

    // Two-stage vsync sample: current and previous registered values.
    always_ff @(posedge iVGA_CLK) begin
        if (reset_game) begin
            vsync_cur  <= 1'b0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_cur  <= iVsync;
            vsync_prev <= vsync_cur;
        end
    end

    assign oTick = vsync_prev & ~vsync_cur;

endmodule

// File: rtl/race_game_ctrl.sv
// Game-flow controller for the racing game. Sequences the obstacle movers
// (move strobe, velocity, clear request), tracks score and speed level and
// runs the IDLE/COUNTDOWN/RUN/CRASH/GAMEOVER state machine.
// Optional build macro SPEED_RAMP_EN: when defined, every PASS_PER_LEVEL
// obstacles passed in RUN raise the level and the velocity; when undefined
// the level stays 0 and the velocity stays at VEL_INIT.
module race_game_ctrl
    import race_pkg::*;
#(
    parameter int unsigned FRAME_DIV        = 1,
    parameter int unsigned VEL_INIT         = 2,
    parameter int unsigned VEL_MAX          = 8,
    parameter int unsigned PASS_PER_LEVEL   = 10,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned CRASH_FRAMES     = 120
) (
    input  logic                iVGA_CLK,
    input  logic                reset_game,
    input  logic                iStart,
    input  logic                iVsync,
    input  logic                iCollision,
    input  logic                iObs_passed,
    output logic [2:0]          oState,
    output logic                oMove_stb,
    output logic [VEL_W-1:0]    oVel,
    output logic                oObs_clear,
    output logic [SCORE_W-1:0]  oScore,
    output logic [LEVEL_W-1:0]  oLevel,
    output logic                oBlink
);

    localparam logic [7:0]       DIV_N   = 8'(FRAME_DIV);
    localparam logic [7:0]       CD_N    = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0]       CRASH_N = 8'(CRASH_FRAMES);
    localparam logic [VEL_W-1:0] VEL_START = VEL_W'(VEL_INIT);

    // Parameter range guard: an out-of-range configuration elaborates this
    // empty block, which makes a bad override easy to spot in the hierarchy.
    if (PASS_PER_LEVEL < 1 || PASS_PER_LEVEL > 255 ||
        VEL_MAX < VEL_INIT || VEL_MAX > 15) begin : g_cfg_out_of_range
    end

    race_state_e        state, state_n;
    logic [7:0]         frame_cnt, frame_cnt_n, frame_inc;
    logic [7:0]         div_cnt, div_cnt_n, div_inc;
    logic [SCORE_W-1:0] score_q, score_n;
    logic [LEVEL_W-1:0] level_q, level_n;
    logic [VEL_W-1:0]   vel_q, vel_n;
    logic               blink_n;
    logic               move_stb_n;
    logic               clear_n;
    logic               restart;
    logic               start_q;
    logic               start_ev;
    logic               tick;

`ifdef SPEED_RAMP_EN
    localparam logic [7:0]       PASS_N   = 8'(PASS_PER_LEVEL);
    localparam logic [VEL_W-1:0] VEL_CEIL = VEL_W'(VEL_MAX);
    logic [7:0] pass_cnt, pass_cnt_n, pass_inc;
`endif

    frame_tick_gen u_tick (
        .iVGA_CLK   (iVGA_CLK),
        .reset_game (reset_game),
        .iVsync     (iVsync),
        .oTick      (tick)
    );

    // Start button edge register; a held button gives a single event.
    always_ff @(posedge iVGA_CLK) begin
        if (reset_game) begin
            start_q <= 1'b0;
        end else begin
            start_q <= iStart;
        end
    end

    assign start_ev = iStart & ~start_q;

    // Next-state, counter and output computation for the game FSM.
    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        div_cnt_n   = div_cnt;
        score_n     = score_q;
        level_n     = level_q;
        vel_n       = vel_q;
        blink_n     = oBlink;
        move_stb_n  = 1'b0;
        restart     = 1'b0;
        frame_inc   = frame_cnt + 8'd1;
        div_inc     = div_cnt + 8'd1;
`ifdef SPEED_RAMP_EN
        pass_cnt_n  = pass_cnt;
        pass_inc    = pass_cnt + 8'd1;
`endif

        case (state)
            ST_IDLE: begin
                blink_n = 1'b0;
                restart = start_ev;
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (frame_inc == CD_N) begin
                        state_n     = ST_RUN;
                        frame_cnt_n = 8'd0;
                        div_cnt_n   = 8'd0;
                    end else begin
                        frame_cnt_n = frame_inc;
                    end
                end
            end
            ST_RUN: begin
                if (iCollision) begin
                    // Collision wins: any same-cycle strobe or pass is dropped.
                    state_n     = ST_CRASH;
                    frame_cnt_n = 8'd0;
                    div_cnt_n   = 8'd0;
                    blink_n     = 1'b1;
`ifdef SPEED_RAMP_EN
                    pass_cnt_n  = 8'd0;
`endif
                end else begin
                    if (tick) begin
                        if (div_inc == DIV_N) begin
                            move_stb_n = 1'b1;
                            div_cnt_n  = 8'd0;
                        end else begin
                            div_cnt_n  = div_inc;
                        end
                    end
                    if (iObs_passed) begin
                        if (score_q != SCORE_MAX) begin
                            score_n = score_q + 14'd1;
                        end
`ifdef SPEED_RAMP_EN
                        if (pass_inc == PASS_N) begin
                            pass_cnt_n = 8'd0;
                            if (level_q != LEVEL_MAX) begin
                                level_n = level_q + 4'd1;
                            end
                            if (vel_q != VEL_CEIL) begin
                                vel_n = vel_q + 4'd1;
                            end
                        end else begin
                            pass_cnt_n = pass_inc;
                        end
`endif
                    end
                end
            end
            ST_CRASH: begin
                if (tick) begin
                    if (frame_inc == CRASH_N) begin
                        state_n     = ST_GAMEOVER;
                        frame_cnt_n = 8'd0;
                        blink_n     = 1'b0;
                    end else begin
                        frame_cnt_n = frame_inc;
                        if (frame_inc[2:0] == 3'd0) begin
                            blink_n = ~oBlink;
                        end
                    end
                end
            end
            ST_GAMEOVER: begin
                blink_n = 1'b0;
                restart = start_ev;
            end
            default: begin
                state_n     = ST_IDLE;
                frame_cnt_n = 8'd0;
                div_cnt_n   = 8'd0;
                blink_n     = 1'b0;
            end
        endcase

        // New game: everything returns to its initial value.
        if (restart) begin
            state_n     = ST_COUNTDOWN;
            frame_cnt_n = 8'd0;
            div_cnt_n   = 8'd0;
            score_n     = '0;
            level_n     = '0;
            vel_n       = VEL_START;
            blink_n     = 1'b0;
`ifdef SPEED_RAMP_EN
            pass_cnt_n  = 8'd0;
`endif
        end

        clear_n = (state_n == ST_IDLE) || (state_n == ST_COUNTDOWN);
    end

    // State, counter and output registers.
    always_ff @(posedge iVGA_CLK) begin
        if (reset_game) begin
            state      <= ST_IDLE;
            frame_cnt  <= 8'd0;
            div_cnt    <= 8'd0;
            score_q    <= '0;
            level_q    <= '0;
            vel_q      <= VEL_START;
            oBlink     <= 1'b0;
            oMove_stb  <= 1'b0;
            oObs_clear <= 1'b1;
`ifdef SPEED_RAMP_EN
            pass_cnt   <= 8'd0;
`endif
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_cnt_n;
            div_cnt    <= div_cnt_n;
            score_q    <= score_n;
            level_q    <= level_n;
            vel_q      <= vel_n;
            oBlink     <= blink_n;
            oMove_stb  <= move_stb_n;
            oObs_clear <= clear_n;
`ifdef SPEED_RAMP_EN
            pass_cnt   <= pass_cnt_n;
`endif
        end
    end

    assign oState = state;
    assign oScore = score_q;
    assign oLevel = level_q;
    assign oVel   = vel_q;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Directed bench for race_game_ctrl. Two instances share all inputs: one
// with FRAME_DIV=1 (latency and general flow) and one with FRAME_DIV=3
// (move strobe division). Expected values are hand-computed constants.
module tb_race_game_ctrl;

`ifdef SPEED_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        iVGA_CLK = 1'b0;
    logic        reset_game;
    logic        iStart;
    logic        iVsync;
    logic        iCollision;
    logic        iObs_passed;

    logic [2:0]  state_a, state_b;
    logic        stb_a, stb_b;
    logic [3:0]  vel_a, vel_b;
    logic        clear_a, clear_b;
    logic [13:0] score_a, score_b;
    logic [3:0]  level_a, level_b;
    logic        blink_a, blink_b;

    int tests  = 0;
    int failed = 0;
    int na = 0;
    int nb = 0;
    int multi_b = 0;
    logic prev_b = 1'b0;

    race_game_ctrl #(.FRAME_DIV(1)) dut_a (
        .iVGA_CLK    (iVGA_CLK),
        .reset_game  (reset_game),
        .iStart      (iStart),
        .iVsync      (iVsync),
        .iCollision  (iCollision),
        .iObs_passed (iObs_passed),
        .oState      (state_a),
        .oMove_stb   (stb_a),
        .oVel        (vel_a),
        .oObs_clear  (clear_a),
        .oScore      (score_a),
        .oLevel      (level_a),
        .oBlink      (blink_a)
    );

    race_game_ctrl #(.FRAME_DIV(3)) dut_b (
        .iVGA_CLK    (iVGA_CLK),
        .reset_game  (reset_game),
        .iStart      (iStart),
        .iVsync      (iVsync),
        .iCollision  (iCollision),
        .iObs_passed (iObs_passed),
        .oState      (state_b),
        .oMove_stb   (stb_b),
        .oVel        (vel_b),
        .oObs_clear  (clear_b),
        .oScore      (score_b),
        .oLevel      (level_b),
        .oBlink      (blink_b)
    );

    // 25 MHz clock
    always #20 iVGA_CLK = ~iVGA_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; sample 1 time unit after each edge and tally strobes.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iVGA_CLK);
            #1;
            if (stb_a) na++;
            if (stb_b) nb++;
            if (stb_b && prev_b) multi_b++;
            prev_b = stb_b;
        end
    endtask

    // One 4-cycle frame: vsync low 2 cycles, high 2 cycles. The tick's
    // effect is registered by the end of the low phase.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            iVsync = 1'b0;
            cycles(2);
            iVsync = 1'b1;
            cycles(2);
        end
    endtask

    task automatic passes(input int n);
        for (int i = 0; i < n; i++) begin
            iObs_passed = 1'b1;
            cycles(1);
            iObs_passed = 1'b0;
            cycles(1);
        end
    endtask

    task automatic start_game();
        iStart = 1'b1;
        cycles(1);
        iStart = 1'b0;
        cycles(1);
    endtask

    initial begin
        // Reset
        reset_game  = 1'b1;
        iStart      = 1'b0;
        iVsync      = 1'b1;
        iCollision  = 1'b0;
        iObs_passed = 1'b0;
        cycles(3);
        reset_game = 1'b0;
        cycles(2);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_score", 32'(score_a), 32'd0);
        check("rst_vel", 32'(vel_a), 32'd2);
        check("rst_clear", 32'(clear_a), 32'd1);
        check("rst_stb", 32'(stb_a), 32'd0);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_blink", 32'(blink_a), 32'd0);

        // Countdown: 179 ticks stay in COUNTDOWN, the 180th enters RUN
        start_game();
        check("cd_state", 32'(state_a), 32'd1);
        check("cd_clear", 32'(clear_a), 32'd1);
        frames(179);
        check("cd_179_state", 32'(state_a), 32'd1);
        frames(1);
        check("cd_180_state", 32'(state_a), 32'd2);
        check("run_clear", 32'(clear_a), 32'd0);
        check("run_state_b", 32'(state_b), 32'd2);

        // First move strobe two cycles after the vsync fall (FRAME_DIV=1)
        na = 0;
        nb = 0;
        multi_b = 0;
        iVsync = 1'b0;
        cycles(1);
        check("lat_c1", 32'(stb_a), 32'd0);
        cycles(1);
        check("lat_c2", 32'(stb_a), 32'd1);
        iVsync = 1'b1;
        cycles(1);
        check("lat_c3", 32'(stb_a), 32'd0);
        cycles(1);

        // 8 more frames (9 total) with start held: 3 strobes at FRAME_DIV=3
        iStart = 1'b1;
        frames(8);
        iStart = 1'b0;
        cycles(1);
        check("div1_pulses", 32'(na), 32'd9);
        check("div3_pulses", 32'(nb), 32'd3);
        check("div3_single", 32'(multi_b), 32'd0);
        check("held_start_state", 32'(state_a), 32'd2);

        // Score and speed ramp
        passes(9);
        check("score_9", 32'(score_a), 32'd9);
        check("vel_9", 32'(vel_a), 32'd2);
        iObs_passed = 1'b1;
        cycles(1);
        iObs_passed = 1'b0;
        check("vel_10_next", 32'(vel_a), RAMP ? 32'd3 : 32'd2);
        cycles(1);
        check("score_10", 32'(score_a), 32'd10);
        check("level_10", 32'(level_a), RAMP ? 32'd1 : 32'd0);
        passes(70);
        check("score_80", 32'(score_a), 32'd80);
        check("level_80", 32'(level_a), RAMP ? 32'd8 : 32'd0);
        check("vel_80", 32'(vel_a), RAMP ? 32'd8 : 32'd2);
        passes(10);
        check("vel_90_cap", 32'(vel_a), RAMP ? 32'd8 : 32'd2);
        check("level_90", 32'(level_a), RAMP ? 32'd9 : 32'd0);

        // Collision on the tick cycle together with a pass: both dropped
        na = 0;
        iVsync = 1'b0;
        cycles(1);
        iCollision  = 1'b1;
        iObs_passed = 1'b1;
        cycles(1);
        iCollision  = 1'b0;
        iObs_passed = 1'b0;
        check("crash_state", 32'(state_a), 32'd3);
        check("crash_score", 32'(score_a), 32'd90);
        check("crash_stb", 32'(stb_a), 32'd0);
        check("crash_blink0", 32'(blink_a), 32'd1);
        check("crash_clear", 32'(clear_a), 32'd0);
        iVsync = 1'b1;
        cycles(2);
        check("crash_no_stb", 32'(na), 32'd0);

        // Blink toggles every 8 ticks; GAMEOVER on the 120th tick
        frames(7);
        check("blink_t7", 32'(blink_a), 32'd1);
        frames(1);
        check("blink_t8", 32'(blink_a), 32'd0);
        frames(8);
        check("blink_t16", 32'(blink_a), 32'd1);
        frames(103);
        check("crash_t119", 32'(state_a), 32'd3);
        frames(1);
        check("gameover_state", 32'(state_a), 32'd4);
        check("gameover_blink", 32'(blink_a), 32'd0);
        check("gameover_clear", 32'(clear_a), 32'd0);
        check("gameover_score", 32'(score_a), 32'd90);
        passes(2);
        check("gameover_ignore_pass", 32'(score_a), 32'd90);

        // Restart from GAMEOVER reinitialises everything
        iStart = 1'b1;
        cycles(1);
        check("restart_state", 32'(state_a), 32'd1);
        check("restart_score", 32'(score_a), 32'd0);
        check("restart_vel", 32'(vel_a), 32'd2);
        check("restart_level", 32'(level_a), 32'd0);
        check("restart_clear", 32'(clear_a), 32'd1);
        iStart = 1'b0;
        cycles(1);

        // Reset in the middle of RUN with score 37
        frames(180);
        check("game2_run", 32'(state_a), 32'd2);
        passes(37);
        check("game2_score", 32'(score_a), 32'd37);
        reset_game = 1'b1;
        cycles(1);
        reset_game = 1'b0;
        check("midrst_state", 32'(state_a), 32'd0);
        check("midrst_score", 32'(score_a), 32'd0);
        check("midrst_vel", 32'(vel_a), 32'd2);
        check("midrst_clear", 32'(clear_a), 32'd1);
        check("midrst_stb", 32'(stb_a), 32'd0);
        check("midrst_level", 32'(level_a), 32'd0);
        cycles(1);

        // Score saturation at 9999
        start_game();
        frames(180);
        check("game3_run", 32'(state_a), 32'd2);
        passes(9999);
        check("sat_score", 32'(score_a), 32'd9999);
        check("sat_level", 32'(level_a), RAMP ? 32'd15 : 32'd0);
        check("sat_vel", 32'(vel_a), RAMP ? 32'd8 : 32'd2);
        passes(1);
        check("sat_score_hold", 32'(score_a), 32'd9999);
        check("sat_score_b", 32'(score_b), 32'd9999);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
